// File: rtl/conv_pkg.sv
// Shared state encoding and width helpers for the separable-convolution front end.
// The line buffer and column filter size their ports with the same helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        PAD      = 3'd2,
        WAIT_EOF = 3'd3,
        DONE     = 3'd4
    } seq_state_e;

    function automatic int pad_rows(input int kernel_h);
        return kernel_h / 2;
    endfunction

    function automatic int w_bits(input int max_img_w);
        return $clog2(max_img_w + 1);
    endfunction

    function automatic int h_bits(input int max_img_h);
        return $clog2(max_img_h + 1);
    endfunction

    function automatic int row_bits(input int max_img_h, input int pad);
        return $clog2(max_img_h + pad + 1);
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Configuration, upstream pixel and downstream marked-beat handshakes of the frame sequencer.
interface conv_frame_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int W_W    = 10,
    parameter int H_W    = 9
);
    logic              i_cfg_vld;
    logic [W_W-1:0]    i_cfg_width;
    logic [H_W-1:0]    i_cfg_height;
    logic              o_cfg_rdy;
    logic              i_vld;
    logic [DATA_W-1:0] i_data;
    logic              o_rdy;
    logic              i_rdy;
    logic              o_vld;
    logic              o_eor;
    logic              o_eof;
    logic [DATA_W-1:0] o_data;

    modport slave (
        input  i_cfg_vld, i_cfg_width, i_cfg_height, i_vld, i_data, i_rdy,
        output o_cfg_rdy, o_rdy, o_vld, o_eor, o_eof, o_data
    );

    modport master (
        output i_cfg_vld, i_cfg_width, i_cfg_height, i_vld, i_data, i_rdy,
        input  o_cfg_rdy, o_rdy, o_vld, o_eor, o_eof, o_data
    );
endinterface

// File: rtl/frame_xy_counter.sv
// Column/row position within a frame plus the latched (clamped) frame size.
// Flags describe the beat about to be emitted; i_adv moves to the next position.
module frame_xy_counter
    import conv_pkg::*;
#(
    parameter int MAX_IMG_W = 640,
    parameter int MAX_IMG_H = 480,
    parameter int PAD_ROWS  = 3,
    parameter int W_W       = w_bits(MAX_IMG_W),
    parameter int H_W       = h_bits(MAX_IMG_H)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_load,
    input  logic [W_W-1:0] i_width,
    input  logic [H_W-1:0] i_height,
    input  logic           i_adv,
    output logic           o_eor,
    output logic           o_last_row,
    output logic           o_last_pad_row
);
    localparam int R_W = row_bits(MAX_IMG_H, PAD_ROWS);

    logic [W_W-1:0] col_q, col_d, width_q, width_d, width_clamp;
    logic [R_W-1:0] row_q, row_d;
    logic [H_W-1:0] height_q, height_d, height_clamp;

    always_comb begin
        width_clamp = i_width;
        if (i_width == '0)
            width_clamp = W_W'(1);
        else if (i_width > W_W'(MAX_IMG_W))
            width_clamp = W_W'(MAX_IMG_W);

        height_clamp = i_height;
        if (i_height == '0)
            height_clamp = H_W'(1);
        else if (i_height > H_W'(MAX_IMG_H))
            height_clamp = H_W'(MAX_IMG_H);
    end

    assign o_eor          = (col_q == width_q - W_W'(1));
    assign o_last_row     = (row_q == R_W'(height_q) - R_W'(1));
    // Padding rows continue the row count past the image, so the last one sits at height+PAD_ROWS-1.
    assign o_last_pad_row = (row_q == R_W'(height_q) + R_W'(PAD_ROWS) - R_W'(1));

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        width_d  = width_q;
        height_d = height_q;
        if (i_load) begin
            width_d  = width_clamp;
            height_d = height_clamp;
            col_d    = '0;
            row_d    = '0;
        end else if (i_adv) begin
            if (o_eor) begin
                col_d = '0;
                row_d = row_q + R_W'(1);
            end else begin
                col_d = col_q + W_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Turns a raw pixel stream plus per-frame size into eor/eof-marked beats for the line buffer,
// appending KERNEL_H/2 padding rows so the vertical window flushes the bottom border.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                KERNEL_H  = 7,
    parameter int                MAX_IMG_W = 640,
    parameter int                MAX_IMG_H = 480,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    conv_frame_sequencer_if.slave bus,
    output logic                 o_busy,
    output logic                 o_frame_done
);
    localparam int PAD_ROWS = pad_rows(KERNEL_H);
    localparam int W_W      = w_bits(MAX_IMG_W);
    localparam int H_W      = h_bits(MAX_IMG_H);

    seq_state_e        state_q, state_d;
    logic              vld_q, vld_d, eor_q, eor_d, eof_q, eof_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load_cfg, adv, reg_free;
    logic              at_eor, at_last_row, at_last_pad_row;

    frame_xy_counter #(
        .MAX_IMG_W (MAX_IMG_W),
        .MAX_IMG_H (MAX_IMG_H),
        .PAD_ROWS  (PAD_ROWS),
        .W_W       (W_W),
        .H_W       (H_W)
    ) u_xy (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load         (load_cfg),
        .i_width        (bus.i_cfg_width),
        .i_height       (bus.i_cfg_height),
        .i_adv          (adv),
        .o_eor          (at_eor),
        .o_last_row     (at_last_row),
        .o_last_pad_row (at_last_pad_row)
    );

    // Single output register: it may reload in the same cycle its current beat is taken.
    assign reg_free = !vld_q || bus.i_rdy;

    always_comb begin
        state_d       = state_q;
        vld_d         = vld_q;
        data_d        = data_q;
        eor_d         = eor_q;
        eof_d         = eof_q;
        load_cfg      = 1'b0;
        adv           = 1'b0;
        bus.o_cfg_rdy = 1'b0;
        bus.o_rdy     = 1'b0;
        if (vld_q && bus.i_rdy)
            vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                bus.o_cfg_rdy = 1'b1;
                if (bus.i_cfg_vld) begin
                    load_cfg = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                bus.o_rdy = reg_free;
                if (bus.i_vld && reg_free) begin
                    vld_d  = 1'b1;
                    data_d = bus.i_data;
                    eor_d  = at_eor;
                    eof_d  = 1'b0;
                    adv    = 1'b1;
                    if (at_eor && at_last_row) begin
                        if (PAD_ROWS > 0) begin
                            state_d = PAD;
                        end else begin
                            eof_d   = 1'b1;
                            state_d = WAIT_EOF;
                        end
                    end
                end
            end
            PAD: begin
                if (reg_free) begin
                    vld_d  = 1'b1;
                    data_d = PAD_VALUE;
                    eor_d  = at_eor;
                    eof_d  = at_eor && at_last_pad_row;
                    adv    = 1'b1;
                    if (at_eor && at_last_pad_row)
                        state_d = WAIT_EOF;
                end
            end
            WAIT_EOF: begin
                if (vld_q && bus.i_rdy && eof_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            eor_q   <= 1'b0;
            eof_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            eor_q   <= eor_d;
            eof_q   <= eof_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_vld    = vld_q;
    assign bus.o_eor    = eor_q;
    assign bus.o_eof    = eof_q;
    assign bus.o_data   = data_q;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = (state_q == DONE);

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: three instances (KERNEL_H = 3, 1, 7) share stimulus,
// and sel picks which one is driven and observed.
module tb_conv_frame_sequencer;
    import conv_pkg::*;

    localparam int W_W = w_bits(640);
    localparam int H_W = h_bits(480);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   sel = 3;

    logic           cfg_vld = 1'b0;
    logic [W_W-1:0] cfg_w = '0;
    logic [H_W-1:0] cfg_h = '0;
    logic           in_vld = 1'b0;
    logic [7:0]     in_data = '0;
    logic           ds_rdy = 1'b1;

    logic       s_vld, s_eor, s_eof, s_rdy, s_cfg_rdy, s_busy, s_done;
    logic [7:0] s_data;
    logic       busy3, busy1, busy7, done3, done1, done7;

    int cmp = 0;
    int fail = 0;

    logic [9:0] beats[$];
    int consumed, stall_err, done_cnt, done_cyc, last_cyc;
    bit cfg_rdy_seen;

    always #5 clk = ~clk;

    conv_frame_sequencer_if #(.DATA_W(8), .W_W(W_W), .H_W(H_W)) b3 ();
    conv_frame_sequencer_if #(.DATA_W(8), .W_W(W_W), .H_W(H_W)) b1 ();
    conv_frame_sequencer_if #(.DATA_W(8), .W_W(W_W), .H_W(H_W)) b7 ();

    conv_frame_sequencer #(.DATA_W(8), .KERNEL_H(3), .MAX_IMG_W(640), .MAX_IMG_H(480), .PAD_VALUE(8'h00))
        u3 (.i_clk(clk), .i_rst(rst), .bus(b3), .o_busy(busy3), .o_frame_done(done3));
    conv_frame_sequencer #(.DATA_W(8), .KERNEL_H(1), .MAX_IMG_W(640), .MAX_IMG_H(480), .PAD_VALUE(8'h00))
        u1 (.i_clk(clk), .i_rst(rst), .bus(b1), .o_busy(busy1), .o_frame_done(done1));
    conv_frame_sequencer #(.DATA_W(8), .KERNEL_H(7), .MAX_IMG_W(640), .MAX_IMG_H(480), .PAD_VALUE(8'h00))
        u7 (.i_clk(clk), .i_rst(rst), .bus(b7), .o_busy(busy7), .o_frame_done(done7));

    assign b3.i_cfg_vld = cfg_vld && (sel == 3);
    assign b1.i_cfg_vld = cfg_vld && (sel == 1);
    assign b7.i_cfg_vld = cfg_vld && (sel == 7);
    assign b3.i_vld = in_vld && (sel == 3);
    assign b1.i_vld = in_vld && (sel == 1);
    assign b7.i_vld = in_vld && (sel == 7);
    assign b3.i_cfg_width = cfg_w;  assign b3.i_cfg_height = cfg_h;
    assign b1.i_cfg_width = cfg_w;  assign b1.i_cfg_height = cfg_h;
    assign b7.i_cfg_width = cfg_w;  assign b7.i_cfg_height = cfg_h;
    assign b3.i_data = in_data;  assign b1.i_data = in_data;  assign b7.i_data = in_data;
    assign b3.i_rdy = ds_rdy;    assign b1.i_rdy = ds_rdy;    assign b7.i_rdy = ds_rdy;

    assign s_vld     = (sel == 1) ? b1.o_vld     : (sel == 7) ? b7.o_vld     : b3.o_vld;
    assign s_eor     = (sel == 1) ? b1.o_eor     : (sel == 7) ? b7.o_eor     : b3.o_eor;
    assign s_eof     = (sel == 1) ? b1.o_eof     : (sel == 7) ? b7.o_eof     : b3.o_eof;
    assign s_data    = (sel == 1) ? b1.o_data    : (sel == 7) ? b7.o_data    : b3.o_data;
    assign s_rdy     = (sel == 1) ? b1.o_rdy     : (sel == 7) ? b7.o_rdy     : b3.o_rdy;
    assign s_cfg_rdy = (sel == 1) ? b1.o_cfg_rdy : (sel == 7) ? b7.o_cfg_rdy : b3.o_cfg_rdy;
    assign s_busy    = (sel == 1) ? busy1        : (sel == 7) ? busy7        : busy3;
    assign s_done    = (sel == 1) ? done1        : (sel == 7) ? done7        : done3;

    // Expected beat i of a w x h frame with p padding rows: {data, eor, eof}; pixels count from 1.
    function automatic logic [9:0] exp_beat(input int i, input int w, input int h, input int p);
        logic [7:0] d;
        d = (i < w * h) ? 8'(i + 1) : 8'h00;
        return {d, ((i % w) == w - 1), (i == w * (h + p) - 1)};
    endfunction

    task automatic send_cfg(input int w, input int h);
        @(negedge clk);
        cfg_vld = 1'b1;
        cfg_w   = W_W'(w);
        cfg_h   = H_W'(h);
        @(negedge clk);
        cfg_vld = 1'b0;
    endtask

    // Feeds pixels 1..npix and records every accepted output beat until frame_done (or maxb beats).
    task automatic drive_frame(input int npix, input bit stall, input bit poke, input int maxb);
        int         cyc;
        bit         hold;
        logic [9:0] prev;
        cyc = 0; hold = 0; prev = '0;
        beats.delete();
        consumed = 0; stall_err = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; cfg_rdy_seen = 0;
        while (cyc < 400) begin
            @(negedge clk);
            ds_rdy  = stall ? (cyc % 3 == 0) : 1'b1;
            in_vld  = (consumed < npix) && (stall ? ($urandom_range(1, 0) == 1) : 1'b1);
            in_data = 8'(consumed + 1);
            cfg_vld = poke && (cyc == 3);
            if (poke) begin cfg_w = W_W'(2); cfg_h = H_W'(2); end
            #1;
            if (cfg_vld && s_cfg_rdy) cfg_rdy_seen = 1;
            if (hold && (!s_vld || {s_data, s_eor, s_eof} !== prev)) stall_err++;
            hold = s_vld && !ds_rdy;
            prev = {s_data, s_eor, s_eof};
            if (s_vld && ds_rdy) begin beats.push_back({s_data, s_eor, s_eof}); last_cyc = cyc; end
            if (in_vld && s_rdy) consumed++;
            if (s_done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            cyc++;
            if (maxb > 0 && beats.size() == maxb) break;
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        cfg_vld = 1'b0;
        in_vld  = 1'b0;
    endtask

    task automatic test_reset();
        sel = 3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp++; if (s_vld !== 1'b0)    begin fail++; $display("FAIL reset_vld: got %b want 0", s_vld); end
        cmp++; if (s_eor !== 1'b0)    begin fail++; $display("FAIL reset_eor: got %b want 0", s_eor); end
        cmp++; if (s_eof !== 1'b0)    begin fail++; $display("FAIL reset_eof: got %b want 0", s_eof); end
        cmp++; if (s_data !== 8'h00)  begin fail++; $display("FAIL reset_data: got %0d want 0", s_data); end
        cmp++; if (s_busy !== 1'b0)   begin fail++; $display("FAIL reset_busy: got %b want 0", s_busy); end
        cmp++; if (s_done !== 1'b0)   begin fail++; $display("FAIL reset_done: got %b want 0", s_done); end
        rst = 1'b0;
        @(negedge clk);
        cmp++; if (s_cfg_rdy !== 1'b1) begin fail++; $display("FAIL idle_cfg_rdy: got %b want 1", s_cfg_rdy); end
        cmp++; if (s_rdy !== 1'b0)     begin fail++; $display("FAIL idle_rdy: got %b want 0", s_rdy); end
    endtask

    task automatic test_basic_pad();
        sel = 3;
        send_cfg(4, 3);
        drive_frame(12, 0, 0, 0);
        cmp++; if (beats.size() !== 16) begin fail++; $display("FAIL basic_count: got %0d want 16", beats.size()); end
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            cmp++;
            if (beats[i] !== exp_beat(i, 4, 3, 1)) begin
                fail++; $display("FAIL basic_beat%0d: got %h want %h", i, beats[i], exp_beat(i, 4, 3, 1));
            end
        end
        cmp++; if (done_cyc !== last_cyc + 1) begin fail++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_cyc + 1); end
        cmp++; if (done_cnt !== 1) begin fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        cmp++; if (s_busy !== 1'b0) begin fail++; $display("FAIL basic_idle_after: got busy=%b want 0", s_busy); end
    endtask

    task automatic test_stall();
        sel = 3;
        send_cfg(4, 3);
        drive_frame(12, 1, 0, 0);
        cmp++; if (beats.size() !== 16) begin fail++; $display("FAIL stall_count: got %0d want 16", beats.size()); end
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            cmp++;
            if (beats[i] !== exp_beat(i, 4, 3, 1)) begin
                fail++; $display("FAIL stall_beat%0d: got %h want %h", i, beats[i], exp_beat(i, 4, 3, 1));
            end
        end
        cmp++; if (stall_err !== 0) begin fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_err); end
        cmp++; if (consumed !== 12) begin fail++; $display("FAIL stall_consumed: got %0d want 12", consumed); end
        cmp++; if (done_cyc !== last_cyc + 1) begin fail++; $display("FAIL stall_done_time: got %0d want %0d", done_cyc, last_cyc + 1); end
    endtask

    task automatic test_no_pad();
        sel = 1;
        send_cfg(3, 2);
        drive_frame(6, 0, 0, 0);
        cmp++; if (beats.size() !== 6) begin fail++; $display("FAIL nopad_count: got %0d want 6", beats.size()); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            cmp++;
            if (beats[i] !== exp_beat(i, 3, 2, 0)) begin
                fail++; $display("FAIL nopad_beat%0d: got %h want %h", i, beats[i], exp_beat(i, 3, 2, 0));
            end
        end
        cmp++; if (done_cnt !== 1) begin fail++; $display("FAIL nopad_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_clamp();
        sel = 7;
        send_cfg(0, 0);
        drive_frame(1, 0, 0, 0);
        cmp++; if (beats.size() !== 4) begin fail++; $display("FAIL clamp_count: got %0d want 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            cmp++;
            if (beats[i] !== exp_beat(i, 1, 1, 3)) begin
                fail++; $display("FAIL clamp_beat%0d: got %h want %h", i, beats[i], exp_beat(i, 1, 1, 3));
            end
        end
        cmp++; if (consumed !== 1) begin fail++; $display("FAIL clamp_consumed: got %0d want 1", consumed); end
    endtask

    task automatic test_cfg_ignore();
        sel = 3;
        send_cfg(4, 3);
        drive_frame(12, 0, 1, 0);
        cmp++; if (cfg_rdy_seen !== 1'b0) begin fail++; $display("FAIL ignore_cfg_rdy: got %b want 0", cfg_rdy_seen); end
        cmp++; if (beats.size() !== 16) begin fail++; $display("FAIL ignore_count: got %0d want 16", beats.size()); end
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            cmp++;
            if (beats[i] !== exp_beat(i, 4, 3, 1)) begin
                fail++; $display("FAIL ignore_beat%0d: got %h want %h", i, beats[i], exp_beat(i, 4, 3, 1));
            end
        end
    endtask

    task automatic test_reset_mid_pad();
        sel = 3;
        send_cfg(2, 2);
        drive_frame(4, 0, 0, 4);
        @(negedge clk);
        ds_rdy = 1'b0;
        #1;
        cmp++; if ({s_vld, s_busy, s_data} !== {1'b1, 1'b1, 8'h00}) begin
            fail++; $display("FAIL midpad_held: got vld=%b busy=%b data=%0d want 1 1 0", s_vld, s_busy, s_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp++; if (s_vld !== 1'b0)     begin fail++; $display("FAIL midpad_rst_vld: got %b want 0", s_vld); end
        cmp++; if (s_busy !== 1'b0)    begin fail++; $display("FAIL midpad_rst_busy: got %b want 0", s_busy); end
        cmp++; if (s_cfg_rdy !== 1'b1) begin fail++; $display("FAIL midpad_rst_cfg_rdy: got %b want 1", s_cfg_rdy); end
        ds_rdy = 1'b1;
        send_cfg(2, 2);
        drive_frame(4, 0, 0, 0);
        cmp++; if (beats.size() !== 6) begin fail++; $display("FAIL fresh_count: got %0d want 6", beats.size()); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            cmp++;
            if (beats[i] !== exp_beat(i, 2, 2, 1)) begin
                fail++; $display("FAIL fresh_beat%0d: got %h want %h", i, beats[i], exp_beat(i, 2, 2, 1));
            end
        end
        cmp++; if (done_cnt !== 1) begin fail++; $display("FAIL fresh_done_cnt: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_pad();
        test_stall();
        test_no_pad();
        test_clamp();
        test_cfg_ignore();
        test_reset_mid_pad();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
Front-end controller for the separable-convolution line buffer. It takes a raw, unmarked pixel stream plus a per-frame width/height configuration, and emits the valid/ready stream with end-of-row (eor) and end-of-frame (eof) markers that the line buffer consumes. After the last real row it injects KERNEL_H/2 padding rows so the vertical window flushes the bottom image border. It then signals frame completion and returns to idle for the next configuration.

Parameters:
DATA_W, 8, pixel width in bits
KERNEL_H, 7, vertical kernel height; PAD_ROWS = KERNEL_H/2 (integer division)
MAX_IMG_W, 640, maximum frame width in pixels
MAX_IMG_H, 480, maximum frame height in rows
PAD_VALUE, 0, DATA_W-bit value driven on padding pixels

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_cfg_vld  in  1  configuration valid
i_cfg_width  in  W_W  frame width; W_W = $clog2(MAX_IMG_W+1)
i_cfg_height  in  H_W  frame height; H_W = $clog2(MAX_IMG_H+1)
o_cfg_rdy  out  1  configuration accepted this cycle when high with i_cfg_vld
i_vld  in  1  upstream pixel valid
i_data  in  DATA_W  upstream pixel
o_rdy  out  1  upstream ready
i_rdy  in  1  downstream ready
o_vld  out  1  output beat valid
o_eor  out  1  beat is last pixel of a row
o_eof  out  1  beat is last pixel of the frame, including padding
o_data  out  DATA_W  output pixel
o_busy  out  1  high in every state except IDLE
o_frame_done  out  1  one-cycle pulse after the eof beat is accepted

Behaviour:
- Reset values: o_vld=0, o_eor=0, o_eof=0, o_data=0, o_frame_done=0, o_busy=0. State = IDLE, all counters = 0. Reset mid-frame drops any held beat and discards the latched configuration.
- Output stage: a single register, so latency from input acceptance to o_vld is 1 cycle.
  - The register loads when (!o_vld || i_rdy); load and downstream acceptance can occur in the same cycle.
  - While o_vld && !i_rdy, o_data, o_eor and o_eof hold stable.
- Configuration clamping: width 0 is treated as 1 and width > MAX_IMG_W as MAX_IMG_W. Height is clamped the same way to [1, MAX_IMG_H].
- IDLE:
  - o_cfg_rdy=1, o_rdy=0.
  - On i_cfg_vld, latch the clamped width and height, clear the column and row counters, and go to STREAM.
- STREAM:
  - o_cfg_rdy=0, o_rdy = (!o_vld || i_rdy).
  - Each accepted pixel loads the output register and advances col.
  - eor = (col == width-1). On eor, col resets to 0 and row increments.
  - On the last row's eor beat:
    - If PAD_ROWS > 0, go to PAD; that beat has eof=0.
    - If PAD_ROWS == 0, that beat carries eof=1 and the state goes to WAIT_EOF.
- PAD:
  - o_rdy=0; upstream is never consumed.
  - Whenever the register is free, load a PAD_VALUE beat and advance col/row as in STREAM.
  - eor is asserted on every width-th beat.
  - The final pixel of padding row PAD_ROWS-1 carries eof=1; then go to WAIT_EOF.
- WAIT_EOF:
  - o_rdy=0; hold until o_vld && i_rdy && o_eof.
  - Then go to DONE.
- DONE:
  - o_frame_done=1 for exactly one cycle, then IDLE.
  - The next configuration may be accepted on the following cycle.
- Configuration presented outside IDLE is ignored (o_cfg_rdy=0) and must be held by the sender.
- Total beats per frame = width*(height+PAD_ROWS). eor count = height+PAD_ROWS. eof appears exactly once per frame.
- Counter widths: col uses W_W bits. row uses $clog2(MAX_IMG_H+PAD_ROWS+1) bits. Counters never wrap inside a frame.

Decomposition:
- Shared package conv_pkg holds:
  - state localparams IDLE/STREAM/PAD/WAIT_EOF/DONE (3-bit encoding);
  - the PAD_ROWS derivation function;
  - the W_W/H_W width helpers, which the line buffer and column filter reuse.
- One sub-module is natural: frame_xy_counter. It holds the col/row counters with an advance enable, the latched width/height, and the eor / last_row / last_pad_row flags, keeping the FSM file focused on handshakes.

Test Plan:
- KERNEL_H=3, cfg 4x3, upstream pixels 1..12, i_rdy=1 -> 16 beats: data 1..12 then four zeros; eor on beats 4,8,12,16; eof only on beat 16; o_frame_done pulses 1 cycle after beat 16.
- Same config, i_rdy toggling 1-in-3 and i_vld random -> identical beat sequence; the output holds stable under stall; no upstream pixel is lost or duplicated.
- KERNEL_H=1, cfg 3x2 -> 6 beats, no padding; eof coincides with eor on pixel 6.
- cfg width=0, height=0 -> clamped 1x1 with KERNEL_H=7: 4 beats, each with eor=1, eof on the 4th beat.
- i_cfg_vld pulsed during STREAM with different values -> ignored, o_cfg_rdy=0, and the original dimensions are honoured.
- Reset asserted mid-PAD with o_vld=1 -> next cycle o_vld=0, o_busy=0, state IDLE; a fresh 2x2 frame then runs cleanly.
